mem_dump_uart: RTL and testbench



---
 rtl/mem_dump_uart.sv | 109 ++++++++++
 tb/tb_mem_dump_uart.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_uart.sv
// Walks SAP memory 0..15 after a start pulse and sends each entry as "<A>:<DD>\r\n" over 8N1 UART.
// Latency: start sampled at edge E -> busy at E+1, first start bit at E+2; start is ignored while busy.
module mem_dump_uart #(
    parameter int DIVISOR = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] mem_adr,
    input  logic [7:0] mem_rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SEND} state_t;

    state_t        state;
    logic          start_q;
    logic [7:0]    data_q;
    logic [3:0]    bit_idx;
    logic [2:0]    char_idx;
    logic [DW-1:0] div_cnt;
    logic [7:0]    cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // Hex digits come from the latched byte so memory writes mid-line cannot corrupt the text.
    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            3'd0:    cur_char = hex_ascii(mem_adr);
            3'd1:    cur_char = 8'h3A;
            3'd2:    cur_char = hex_ascii(data_q[7:4]);
            3'd3:    cur_char = hex_ascii(data_q[3:0]);
            3'd4:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_adr  <= 4'd0;
            data_q   <= 8'd0;
            bit_idx  <= 4'd0;
            char_idx <= 3'd0;
            div_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    mem_adr <= 4'd0;
                    if (start_q) begin
                        start_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end else begin
                        start_q <= start;
                    end
                end
                SETTLE: begin
                    data_q   <= mem_rd_data;
                    char_idx <= 3'd0;
                    bit_idx  <= 4'd0;
                    div_cnt  <= '0;
                    tx       <= 1'b0;
                    state    <= SEND;
                end
                SEND: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            // bit_idx 1..8 carry data bits LSB first, 9 is the stop bit
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= (bit_idx == 4'd8) ? 1'b1 : cur_char[bit_idx[2:0]];
                        end else if (char_idx != 3'd5) begin
                            char_idx <= char_idx + 3'd1;
                            bit_idx  <= 4'd0;
                            tx       <= 1'b0;
                        end else if (mem_adr != 4'hF) begin
                            mem_adr <= mem_adr + 4'd1;
                            tx      <= 1'b1;
                            state   <= SETTLE;
                        end else begin
                            mem_adr <= 4'd0;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_uart.sv
// Bench for mem_dump_uart: arithmetic timing model, UART receiver and literal line checks.
module tb_mem_dump_uart;
    localparam int DS = 4;
    localparam int DB = 868;
    localparam int DONE_REL = 17 + 960 * DS;
    localparam int BIG_RUN = 52090;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, start, tx, busy, done;
    logic [3:0] mem_adr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem [16];
    assign mem_rd_data = mem[mem_adr];

    logic       b_reset, b_start, b_tx, b_busy, b_done;
    logic [3:0] b_adr;
    logic [7:0] b_rd;
    logic [7:0] bmem [16];
    assign b_rd = bmem[b_adr];

    mem_dump_uart #(.DIVISOR(DS)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_adr(mem_adr),
        .mem_rd_data(mem_rd_data), .tx(tx), .busy(busy), .done(done)
    );
    mem_dump_uart #(.DIVISOR(DB)) dut_big (
        .clk(clk), .reset(b_reset), .start(b_start), .mem_adr(b_adr),
        .mem_rd_data(b_rd), .tx(b_tx), .busy(b_busy), .done(b_done)
    );

    int errors = 0;
    int checks = 0;

    int         s_start = -1, s_pend = -1, s_abort = -1;
    logic [7:0] s_snap [16];
    logic [7:0] s_pend_snap [16];
    bit         chk_en = 0;
    int         busy_cnt = 0;
    int         b_se = -1;
    bit         b_chk = 0;
    bit         b_fin = 0;
    bit         b_hist [0:BIG_RUN];
    logic [7:0] rx_q [$];

    function automatic logic [7:0] hex_ch(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
    endfunction

    function automatic logic [7:0] line_char(input int i, input int k, input logic [7:0] dat);
        case (k)
            0: return hex_ch(4'(i));
            1: return 8'h3A;
            2: return hex_ch(dat[7:4]);
            3: return hex_ch(dat[3:0]);
            4: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Expected {tx,busy,done,mem_adr} n edges after start was sampled.
    function automatic logic [6:0] exp_out(input int n, input int d, input logic [7:0] snap [16]);
        int lp, i, o, b;
        logic [7:0] ch;
        logic t;
        lp = 1 + 60 * d;
        if (n < 1 || n > 17 + 960 * d) return 7'b100_0000;
        if (n == 17 + 960 * d) return 7'b101_0000;
        if (n < 2) return 7'b110_0000;
        i = (n - 2) / lp;
        o = (n - 2) % lp;
        if (o == 60 * d) return {3'b110, 4'(i + 1)};
        ch = line_char(i, o / (10 * d), snap[i]);
        b = (o % (10 * d)) / d;
        if (b == 0) t = 1'b0;
        else if (b == 9) t = 1'b1;
        else t = ch[b - 1];
        return {t, 2'b10, 4'(i)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic check48(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [47:0] rx_line(input int i);
        logic [47:0] r = '0;
        if (rx_q.size() >= 6 * i + 6)
            for (int j = 0; j < 6; j++) r = {r[39:0], rx_q[6 * i + j]};
        return r;
    endfunction

    task automatic check_rx(input string name);
        logic [47:0] e;
        check({name, "_rx_count"}, rx_q.size(), 96);
        for (int i = 0; i < 16; i++) begin
            e = '0;
            for (int k = 0; k < 6; k++) e = {e[39:0], line_char(i, k, s_snap[i])};
            check48($sformatf("%s_line%0d", name, i), rx_line(i), e);
        end
        rx_q.delete();
    endtask

    // Single compare process: both DUTs against the timing model on every cycle.
    always @(negedge clk) begin : cmp
        int n;
        logic [6:0] e, g;
        if (s_pend >= 0 && cyc >= s_pend) begin
            s_start = s_pend;
            s_snap = s_pend_snap;
            s_pend = -1;
            busy_cnt = 0;
        end
        if (s_abort >= 0 && cyc >= s_abort) begin
            s_start = -1;
            s_abort = -1;
        end
        if (chk_en) begin
            n = (s_start >= 0) ? cyc - s_start : -1;
            e = exp_out(n, DS, s_snap);
            g = {tx, busy, done, mem_adr};
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_small cyc=%0d n=%0d: got tx/busy/done/adr %b required %b", cyc, n, g, e);
            end
        end
        if (b_chk) begin
            n = cyc - b_se;
            e = exp_out(n, DB, bmem);
            g = {b_tx, b_busy, b_done, b_adr};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_big cyc=%0d n=%0d: got tx/busy/done/adr %b required %b", cyc, n, g, e);
            end
            if (n >= 0 && n <= BIG_RUN) b_hist[n] = b_tx;
        end
    end

    // UART receiver sampling the small DUT at bit centres.
    initial begin : rx
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                logic [7:0] b;
                repeat (DS / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (DS) @(negedge clk);
                    b[j] = tx;
                end
                repeat (DS) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_dump(output int se);
        @(posedge clk);
        #1;
        start = 1'b1;
        s_pend_snap = mem;
        s_pend = cyc + 1;
        se = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic raw_pulse_at(input int edge_n);
        wait_cyc(edge_n - 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int at);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 6000);
        at = cyc;
        if (done !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL %s_done_timeout: got no done required done within 6000 cycles", name);
        end
    endtask

    task automatic random_dump(input string name);
        int se, t, r1, r2, r3;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        rx_q.delete();
        start_dump(se);
        r1 = $urandom_range(1200, 2);
        r2 = r1 + $urandom_range(1200, 1);
        r3 = r2 + $urandom_range(1400, 1);
        raw_pulse_at(se + r1);
        raw_pulse_at(se + r2);
        raw_pulse_at(se + r3);
        wait_done(name, t);
        check({name, "_done_edge"}, t - se, DONE_REL);
        check_rx(name);
        @(posedge clk);
        #1;
    endtask

    initial begin : big
        b_reset = 1'b1;
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) bmem[i] = 8'($urandom);
        bmem[0][7:4] = 4'h1;
        @(posedge clk);
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        b_start = 1'b1;
        b_se = cyc + 1;
        b_chk = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        while (cyc < b_se + BIG_RUN) begin
            @(posedge clk);
            #1;
        end
        b_chk = 1'b0;
        check("big_line0_pre", int'(b_hist[1]), 1);
        check("big_line0_start", int'(b_hist[2]), 0);
        begin
            int w, f;
            w = 0;
            while (w < 2000 && b_hist[17362 + w] == 1'b0) w++;
            check("big_start_bit_width", w, 868);
            check("big_char2_pre", int'(b_hist[17361]), 1);
            f = 17362 + 9 * 868;
            while (f < BIG_RUN && b_hist[f] == 1'b1) f++;
            check("big_char_pitch", f - 17362, 8680);
            f = 2 + 59 * 868;
            while (f < BIG_RUN && b_hist[f] == 1'b1) f++;
            check("big_line_pitch", f - 2, 52081);
        end
        b_reset = 1'b1;
        b_fin = 1'b1;
    end

    initial begin : main
        int se, se2, t, g;
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);

        // Reset held three edges with start high
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_adr", int'(mem_adr), 0);

        // Full dump, mem[i] = i*0x11
        rx_q.delete();
        start_dump(se);
        wait_done("s2", t);
        check("s2_done_edge", t - se, DONE_REL);
        check("s2_busy_cycles", busy_cnt, 3856);
        @(negedge clk);
        check("s2_done_width", int'(done), 0);
        check48("s2_line0", rx_line(0), {"0:00", 8'h0D, 8'h0A});
        check48("s2_line3", rx_line(3), {"3:33", 8'h0D, 8'h0A});
        check48("s2_line15", rx_line(15), {"F:FF", 8'h0D, 8'h0A});
        check_rx("s2");
        @(posedge clk);
        #1;

        // Uppercase and data latching: memory cleared during char 1 of each line
        for (int i = 0; i < 16; i++) mem[i] = 8'hAF;
        start_dump(se);
        for (int i = 0; i < 16; i++) begin
            wait_cyc(se + 2 + i * (1 + 60 * DS) + 10 * DS + 3);
            mem[i] = 8'h00;
        end
        wait_done("s3", t);
        check48("s3_line10", rx_line(10), {"A:AF", 8'h0D, 8'h0A});
        check_rx("s3");

        // Starts while busy are ignored; start in the done cycle is accepted
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 8'h11);
        start_dump(se);
        raw_pulse_at(se + 100);
        raw_pulse_at(se + 2000);
        wait_done("s4a", t);
        check("s4a_done_edge", t - se, DONE_REL);
        check_rx("s4a");
        start = 1'b1;
        s_pend_snap = mem;
        s_pend = cyc + 1;
        se2 = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tx !== 1'b0 && g < 20);
        check("s4b_first_start_bit", cyc - se2, 2);
        wait_done("s4b", t);
        check("s4b_done_edge", t - se2, DONE_REL);
        check_rx("s4b");

        // Reset during data bit 3 of line 5
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        start_dump(se);
        wait_cyc(se + 2 + 5 * (1 + 60 * DS) + 4 * DS);
        reset = 1'b1;
        s_abort = cyc + 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("s5_abort_tx", int'(tx), 1);
        check("s5_abort_busy", int'(busy), 0);
        check("s5_abort_adr", int'(mem_adr), 0);
        g = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) g++;
        end
        check("s5_no_done", g, 0);
        rx_q.delete();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        @(posedge clk);
        #1;
        start_dump(se);
        wait_done("s5b", t);
        check("s5b_done_edge", t - se, DONE_REL);
        check_rx("s5b");
        @(posedge clk);
        #1;

        // Random contents with random ignored start pulses
        random_dump("s7a");
        random_dump("s7b");

        g = 0;
        while (!b_fin && g < 70000) begin
            @(posedge clk);
            g++;
        end
        if (!b_fin) begin
            errors++;
            checks++;
            $display("FAIL big_timeout: got unfinished required finished");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
